// File: rtl/baud_rate_gen.sv
// Serial-port timing generator: a free-running machine-cycle tick plus a selectable
// receive-sample tick (16x bit rate) and a transmit bit tick derived from it.
module baud_rate_gen #(
  parameter int unsigned RS232_DIV0 = 104,
  parameter int unsigned RS232_DIV1 = 52,
  parameter int unsigned RS232_DIV2 = 26,
  parameter int unsigned RS232_DIV3 = 13
) (
  input  logic system_clk_i,
  input  logic system_rst_i_b,
  input  logic baud_rate_scon_sm0_i,
  input  logic baud_rate_scon_sm1_i,
  input  logic baud_rate_scon_sm2_i,
  input  logic baud_rate_pcon_smod_i,
  input  logic baud_rate_pcon_rs232_i,
  output logic baud_rate_cm_o,
  output logic baud_rate_br_o,
  output logic baud_rate_br_trans_o
);

  localparam int unsigned Max01  = (RS232_DIV0 > RS232_DIV1) ? RS232_DIV0 : RS232_DIV1;
  localparam int unsigned Max23  = (RS232_DIV2 > RS232_DIV3) ? RS232_DIV2 : RS232_DIV3;
  localparam int unsigned MaxDiv = (Max01 > Max23) ? ((Max01 > 4) ? Max01 : 4)
                                                   : ((Max23 > 4) ? Max23 : 4);
  localparam int unsigned PerW   = $clog2(MaxDiv + 1);

  typedef logic [PerW-1:0] per_t;

  logic [1:0]  mode;
  logic        hold;
  per_t        per_sel;
  logic [3:0]  cm_cnt_q, cm_cnt_d;
  logic        cm_tick;
  per_t        smp_cnt_q, smp_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [PerW+1:0] cfg_q;
  logic        cfg_vld_q;
  logic        restart;
  logic        cm_q, br_q, br_d, trans_q, trans_d;

  assign mode    = {baud_rate_scon_sm0_i, baud_rate_scon_sm1_i};
  assign cm_tick = (cm_cnt_q == 4'd11);
  assign cm_cnt_d = cm_tick ? 4'd0 : cm_cnt_q + 4'd1;

  // Sample period in clocks for the current mode; mode 0 does not use it.
  always_comb begin
    per_sel = '0;
    hold    = 1'b0;
    unique case (mode)
      2'b00: per_sel = '0;
      2'b10: begin
        per_sel = baud_rate_pcon_smod_i ? per_t'(2) : per_t'(4);
        hold    = baud_rate_scon_sm2_i;
      end
      default: begin
        if (baud_rate_pcon_rs232_i) begin
          unique case ({baud_rate_scon_sm2_i, baud_rate_pcon_smod_i})
            2'b00:   per_sel = per_t'(RS232_DIV0);
            2'b01:   per_sel = per_t'(RS232_DIV1);
            2'b10:   per_sel = per_t'(RS232_DIV2);
            default: per_sel = per_t'(RS232_DIV3);
          endcase
        end else begin
          per_sel = baud_rate_pcon_smod_i ? per_t'(2) : per_t'(4);
        end
      end
    endcase
  end

  // A changed mode/period restarts the dividers; hold clears them every cycle.
  assign restart = hold | (cfg_vld_q & ({mode, per_sel} != cfg_q));

  always_comb begin
    smp_cnt_d = smp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    br_d      = 1'b0;
    trans_d   = 1'b0;
    if (mode == 2'b00) begin
      smp_cnt_d = '0;
      bit_cnt_d = '0;
      br_d      = cm_tick;
      trans_d   = cm_tick;
    end else if (restart) begin
      smp_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (smp_cnt_q == per_sel - per_t'(1)) begin
      smp_cnt_d = '0;
      bit_cnt_d = bit_cnt_q + 4'd1;
      br_d      = 1'b1;
      trans_d   = (bit_cnt_q == 4'd15);
    end else begin
      smp_cnt_d = smp_cnt_q + per_t'(1);
    end
  end

  always_ff @(posedge system_clk_i or posedge system_rst_i_b) begin
    if (system_rst_i_b) begin
      cm_cnt_q  <= '0;
      smp_cnt_q <= '0;
      bit_cnt_q <= '0;
      cfg_q     <= '0;
      cfg_vld_q <= 1'b0;
      cm_q      <= 1'b0;
      br_q      <= 1'b0;
      trans_q   <= 1'b0;
    end else begin
      cm_cnt_q  <= cm_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      cfg_q     <= {mode, per_sel};
      cfg_vld_q <= 1'b1;
      cm_q      <= cm_tick;
      br_q      <= br_d;
      trans_q   <= trans_d;
    end
  end

  assign baud_rate_cm_o       = cm_q;
  assign baud_rate_br_o       = br_q;
  assign baud_rate_br_trans_o = trans_q;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen: per-cycle expected pulse patterns for each mode step.
module tb_baud_rate_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sm0 = 1'b0, sm1 = 1'b0, sm2 = 1'b0, smod = 1'b0, rs232 = 1'b0;
  logic cm, br, tr;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;

  baud_rate_gen dut (
    .system_clk_i          (clk),
    .system_rst_i_b        (rst),
    .baud_rate_scon_sm0_i  (sm0),
    .baud_rate_scon_sm1_i  (sm1),
    .baud_rate_scon_sm2_i  (sm2),
    .baud_rate_pcon_smod_i (smod),
    .baud_rate_pcon_rs232_i(rs232),
    .baud_rate_cm_o        (cm),
    .baud_rate_br_o        (br),
    .baud_rate_br_trans_o  (tr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int k, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s k=%0d got %b expected %b", tag, k, got, exp);
    end
  endtask

  // Run n clocks from the current negedge; per==0 means the pulse must never appear.
  task automatic run(input string tag, input int n, input int br_per, input int br_first,
                     input int tr_per, input int tr_first);
    logic e_cm, e_br, e_tr;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      e_cm = (edges % 12 == 0);
      e_br = (br_per > 0) && (k >= br_first) && ((k - br_first) % br_per == 0);
      e_tr = (tr_per > 0) && (k >= tr_first) && ((k - tr_first) % tr_per == 0);
      chk({tag, ".cm"}, k, cm, e_cm);
      chk({tag, ".br"}, k, br, e_br);
      chk({tag, ".tr"}, k, tr, e_tr);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".cm"}, 0, cm, 1'b0);
    chk({tag, ".br"}, 0, br, 1'b0);
    chk({tag, ".tr"}, 0, tr, 1'b0);
  endtask

  int pad;

  initial begin
    // Held in reset: all outputs low.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk_zero("rst_hold");
    end
    rst = 1'b0;
    edges = 0;

    // Mode 0: every output mirrors the machine-cycle tick.
    run("mode0", 60, 12, 12, 12, 12);

    // Mode 2, smod=0: restart edge, then 4-clock samples and 64-clock bits.
    sm0 = 1'b1; sm1 = 1'b0;
    run("mode2_s0", 140, 4, 5, 64, 65);

    // Mode 2, smod=1.
    smod = 1'b1;
    run("mode2_s1", 70, 2, 3, 32, 33);

    // Mode 1 RS232 table, each code.
    sm0 = 1'b0; sm1 = 1'b1; rs232 = 1'b1; sm2 = 1'b1; smod = 1'b1;
    run("rs_div3", 220, 13, 14, 208, 209);
    smod = 1'b0;
    run("rs_div2", 421, 26, 27, 416, 417);
    sm2 = 1'b0; smod = 1'b1;
    run("rs_div1", 840, 52, 53, 832, 833);
    smod = 1'b0;
    run("rs_div0", 1670, 104, 105, 1664, 1665);

    // Mode 2 hold via sm2 mid-bit; after release the first sample lands 4 clocks later.
    sm0 = 1'b1; sm1 = 1'b0; rs232 = 1'b0;
    run("mode2_pre", 30, 4, 5, 64, 65);
    sm2 = 1'b1;
    run("mode2_hold", 5, 0, 0, 0, 0);
    sm2 = 1'b0;
    run("mode2_rel", 70, 4, 4, 64, 64);

    // Back to mode 0 and stop on a cycle where all three outputs are high.
    sm0 = 1'b0; sm1 = 1'b0;
    pad = 12 - (edges % 12);
    run("mode0_pad", pad, 12, pad, 12, pad);
    rst = 1'b1;
    #1;
    chk_zero("rst_async");
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk_zero("rst_mid");
    end
    rst = 1'b0;
    edges = 0;
    run("post_rst", 24, 12, 12, 12, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/baud_rate_gen.md
BAUD_RATE_GEN -- requirements
Module: baud_rate

Interface
REQ-001 Parameter RS232_DIV0, default 104: sample-tick period in clocks, RS232 rate 0.
REQ-002 Parameter RS232_DIV1, default 52: sample-tick period in clocks, RS232 rate 1.
REQ-003 Parameter RS232_DIV2, default 26: sample-tick period in clocks, RS232 rate 2.
REQ-004 Parameter RS232_DIV3, default 13: sample-tick period in clocks, RS232 rate 3.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-006 system_clk_i  in  1  system clock, all state on rising edge.
REQ-007 system_rst_i_b  in  1  asynchronous reset, active-high despite the suffix.
REQ-008 baud_rate_scon_sm0_i  in  1  serial mode bit 0, MSB of mode.
REQ-009 baud_rate_scon_sm1_i  in  1  serial mode bit 1, LSB of mode.
REQ-010 baud_rate_scon_sm2_i  in  1  mode 2: counter clear; modes 1/3: rate-select MSB.
REQ-011 baud_rate_pcon_smod_i  in  1  rate doubler; modes 1/3: rate-select LSB.
REQ-012 baud_rate_pcon_rs232_i  in  1  selects RS232 rate table in modes 1/3.
REQ-013 baud_rate_cm_o  out  1  machine-cycle tick, one-clock pulse.
REQ-014 baud_rate_br_o  out  1  receive sample tick (16x bit rate), one-clock pulse.
REQ-015 baud_rate_br_trans_o  out  1  transmit bit tick, one-clock pulse.

Function
REQ-016 mode = {sm0, sm1}; all outputs SHALL be registered, active-high, one clock wide.
REQ-017 cm_o SHALL be generated by a free-running mod-12 counter.
- Pulses on every 12th rising edge after reset release, first on the 12th.
- Independent of mode inputs.
REQ-018 Mode 0: br_o and br_trans_o SHALL equal cm_o cycle-for-cycle.
REQ-019 Mode 2, smod=0: br_o SHALL pulse every 4 clocks (bit period 64 clocks).
REQ-020 Mode 2, smod=1: br_o SHALL pulse every 2 clocks (bit period 32 clocks).
REQ-021 Modes 1/3, rs232=0: sample period SHALL match mode 2 (4 clocks if smod=0, 2 if smod=1).
REQ-022 Modes 1/3, rs232=1: sample period SHALL be RS232_DIV{sm2,smod}.
- {0,0}: DIV0; {0,1}: DIV1; {1,0}: DIV2; {1,1}: DIV3.
REQ-023 In all modes except mode 0, a mod-16 counter SHALL count br_o pulses.
- br_trans_o pulses in the same cycle as every 16th br_o pulse, so bit period = 16 x sample period.
REQ-024 Sample counter width SHALL hold the largest divisor parameter; divisors below 2 are not supported.
REQ-025 Mode 2 with sm2=1: sample and bit counters SHALL be held at zero, with br_o=br_trans_o=0.
- After sm2 falls, the first br_o occurs one full sample period later.
- The first br_trans_o occurs 16 sample periods later.
REQ-026 Any change in the selected sample period or mode SHALL synchronously clear the sample and bit counters in the cycle after the change.
- No br_o/br_trans_o pulse in that cycle.
- Counting restarts from zero.
REQ-027 The cm counter SHALL NOT be affected by mode, smod, sm2 or rs232 changes.

Reset
REQ-028 While system_rst_i_b=1, all counters SHALL be zero and all outputs 0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL immediately force the REQ-028 state.
REQ-030 After release, counting SHALL start on the first rising edge; no output pulses while reset is held.

Verification
REQ-031 Reset, mode 0, run 60 clocks -> cm_o=br_o=br_trans_o pulse at clocks 12,24,36,48,60.
REQ-032 Mode 2, smod=0, sm2=0 -> br_o every 4 clocks, br_trans_o every 64 clocks, cm_o still every 12.
REQ-033 Switch to mode 2, smod=1 -> no pulse in the cycle after the switch; then br_o every 2 clocks, br_trans_o every 32.
REQ-034 Mode 1, rs232=1, sm2=1, smod=1 -> br_o every 13 clocks, br_trans_o every 208; repeat for the other three codes (104/52/26).
REQ-035 Mode 2, pulse sm2=1 for 5 clocks mid-bit -> br_o/br_trans_o low during hold; first br_o 4 clocks after release (smod=0).
REQ-036 Assert reset mid-stream -> all outputs 0 at once; after release first cm_o on the 12th edge.
